// File: rtl/instruction_fetch_buffer_pkg.sv
// rtl/instruction_fetch_buffer_pkg.sv - shared fetch-stage constants and FSM encoding
package instruction_fetch_buffer_pkg;

  localparam int DEF_AW = 14;
  localparam int DEF_IW = 17;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_buffer_fetch_queue.sv
// rtl/instruction_fetch_buffer_fetch_queue.sv - prefetch FIFO; flush drops all entries
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 31
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [W-1:0]             head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head reads as zero when empty so the consumer never sees stale words.
  assign head_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instruction_fetch_buffer.sv
// rtl/instruction_fetch_buffer.sv - single-outstanding prefetcher feeding a small instruction queue
module instruction_fetch_buffer
  import instruction_fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = DEF_AW,
  parameter int IW    = DEF_IW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [IW-1:0] mem_rdata,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [IW-1:0] instr,
  output logic [AW-1:0] instr_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  fetch_state_t     state;
  logic [AW-1:0]    fetch_addr;
  logic [IW+AW-1:0] head;
  logic [CW-1:0]    q_count;
  logic             q_full;
  logic             q_empty;
  logic             pop;
  logic             push;
  logic             free_slot;

  assign instr_valid = !q_empty;
  assign pop         = instr_valid && instr_ready;
  // A pop in the same cycle frees a slot, so a full queue can still request.
  assign free_slot   = (q_count < FULL_COUNT) || pop;
  assign push        = (state == ST_FETCH) && mem_ack && !redirect && (!q_full || pop);
  assign instr       = head[IW+AW-1:AW];
  assign instr_pc    = head[AW-1:0];

  fetch_queue #(
    .DEPTH (DEPTH),
    .W     (IW + AW)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({mem_rdata, mem_addr}),
    .pop       (pop),
    .flush     (redirect),
    .head_data (head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      fetch_addr <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (redirect) begin
            fetch_addr <= redirect_pc;
          end else if (free_slot) begin
            state    <= ST_FETCH;
            mem_req  <= 1'b1;
            mem_addr <= fetch_addr;
          end
        end
        ST_FETCH: begin
          if (mem_ack) begin
            state      <= ST_IDLE;
            mem_req    <= 1'b0;
            fetch_addr <= redirect ? redirect_pc : fetch_addr + AW'(1);
          end else if (redirect) begin
            // Memory still owes us a word; hold the request and throw it away later.
            state      <= ST_DRAIN;
            fetch_addr <= redirect_pc;
          end
        end
        ST_DRAIN: begin
          if (redirect) fetch_addr <= redirect_pc;
          if (mem_ack) begin
            state   <= ST_IDLE;
            mem_req <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/instruction_fetch_buffer.md
INSTRUCTION_FETCH_BUFFER -- requirements
Module: instruction_fetch_buffer

Interface
REQ-001 Parameter DEPTH, default 4, prefetch queue entries; power of two, minimum 2.
REQ-002 Parameter AW, default 14, instruction address width; matches PC width.
REQ-003 Parameter IW, default 17, instruction word width; matches the instruction input of the fetch/control stage.
REQ-004 Port clk  input  1  the only clock; all state updates on the rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port redirect  input  1  non-sequential PC change (jump, call, return) in this cycle.
REQ-007 Port redirect_pc  input  AW  target address; valid when redirect=1.
REQ-008 Port mem_req  output  1  program-memory read request; held until mem_ack.
REQ-009 Port mem_addr  output  AW  read address; stable while mem_req=1.
REQ-010 Port mem_ack  input  1  one-cycle pulse; mem_rdata valid in the same cycle.
REQ-011 Port mem_rdata  input  IW  returned instruction word.
REQ-012 Port instr_valid  output  1  queue head holds a valid instruction.
REQ-013 Port instr_ready  input  1  consumer accepts the head this cycle.
REQ-014 Port instr  output  IW  queue-head instruction word.
REQ-015 Port instr_pc  output  AW  address the queue-head instruction was fetched from.

Function
REQ-016 FSM states: IDLE (no request in flight), FETCH (request in flight, response kept), DRAIN (request in flight, response discarded).
REQ-017 IDLE -> FETCH when the queue has a free slot; this transition asserts mem_req with mem_addr=fetch_addr.
REQ-018 FETCH: on mem_ack, write {mem_rdata, mem_addr} into the queue, set fetch_addr=fetch_addr+1 (mod 2^AW), and go to IDLE.
REQ-019 Only one request is in flight at a time; a new request is issued no earlier than the cycle after mem_ack.
REQ-020 Free-slot test counts the entry that is popped in the same cycle, so a full queue with a pop may issue a request.
REQ-021 Handshake: a pop occurs when instr_valid and instr_ready; instr and instr_pc are stable while instr_valid=1 and instr_ready=0.
REQ-022 Simultaneous push and pop keep the occupancy count unchanged; a push into a full queue is impossible by construction.
REQ-023 redirect: flush the queue (instr_valid=0 next cycle) and set fetch_addr=redirect_pc.
REQ-024 redirect while in FETCH without mem_ack, go to DRAIN; mem_req stays asserted with the old mem_addr until mem_ack.
REQ-025 DRAIN: mem_ack discards its data and goes to IDLE; the next request uses redirect_pc.
REQ-026 redirect in the same cycle as mem_ack: discard the data, go to IDLE, fetch_addr=redirect_pc.
REQ-027 redirect overrides a same-cycle pop and push; a second redirect in DRAIN updates the target only.
REQ-028 Address wrap: fetch_addr 2^AW-1 increments to 0.
REQ-029 Latency from mem_ack to instr_valid at an empty queue is one cycle (registered queue output).

Reset
REQ-030 rst=1 clears the queue, sets fetch_addr=0 and FSM=IDLE, and drives mem_req=0, instr_valid=0, instr=0, instr_pc=0, mem_addr=0.
REQ-031 rst takes priority over redirect and mem_ack; a mem_ack arriving during rst or in the cycle immediately after it is ignored.
REQ-032 The first request is issued with mem_addr=0 in the first cycle after rst deasserts.

Structure
REQ-033 A shared package holds the FSM state encoding (2 bits) and the AW/IW default constants used by the fetch/control stage.
REQ-034 Sub-module fetch_queue: synchronous DEPTH x (IW+AW) FIFO with push, pop, flush, full, empty and count signals; the FSM stays in the top level.

Verification
REQ-035 Reset, then mem_ack one cycle after each request with instr_ready=1 -> fetch addresses 0,1,2,3 in order; instr_pc matches instr.
REQ-036 Hold instr_ready=0 -> exactly 4 pushes, then mem_req stays 0; release instr_ready -> fetching resumes at 4.
REQ-037 Request at address 5 pending, redirect to 0x100 -> state DRAIN; the word for 5 never appears at instr; the next request address is 0x100.
REQ-038 redirect to 0x200 in the same cycle as mem_ack -> the acked data is dropped; next instr_pc=0x200.
REQ-039 redirect_pc=0x3FFF -> instr_pc sequence is 0x3FFF, then 0x0000.
REQ-040 Assert rst while in FETCH, then send mem_ack -> no push occurs; after release, the first request address is 0.
